// File: rtl/vc_pkg.sv
// Shared definitions for the valid/credit link blocks (arbiter and converter).
// Provides the credit counter width helper and a common credit count type.
package vc_pkg;

    // Width needed to hold a count from 0 up to and including n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned CREDIT_CNT_MAX_W = 8;

    typedef logic [CREDIT_CNT_MAX_W-1:0] credit_cnt_t;

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin pick: lowest set request at or above ptr, with wrap.
// Uses a double-width request vector so the wrap needs no second search.
module vc_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(2 * N);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] masked;
    logic [PW-1:0]  pos;
    int unsigned    ptr_u;

    assign dbl_req = {req, req};

    // Bits below ptr in the lower copy are masked; the upper copy supplies the wrapped requesters.
    always_comb begin
        ptr_u  = 32'(ptr);
        masked = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            masked[i] = dbl_req[i] && (i >= ptr_u);
        end
    end

    always_comb begin
        grant_any = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!grant_any && masked[i]) begin
                grant_any = 1'b1;
                pos       = PW'(i);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        grant     = '0;
        if (grant_any) begin
            grant_idx = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vr_vc_arbiter.sv
// Round-robin arbiter merging REQ_NUM valid/ready requesters onto one valid/credit link.
// Holds the link credit counter so a beat is only sent when a downstream slot exists.
module vr_vc_arbiter
    import vc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CREDIT_NUM = 2,
    parameter int unsigned REQ_NUM    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_data_i,
    input  logic [REQ_NUM-1:0]              req_valid_i,
    output logic [REQ_NUM-1:0]              req_ready_o,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_credit_i,
    output logic [$clog2(REQ_NUM)-1:0]      m_grant_id_o,
    output logic [cnt_w(CREDIT_NUM)-1:0]    credit_cnt_o,
    output logic                            credit_err_o
);

    localparam int unsigned IW = $clog2(REQ_NUM);
    localparam int unsigned CW = cnt_w(CREDIT_NUM);

    logic [IW-1:0]         ptr_q;
    logic [CW-1:0]         credit_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [IW-1:0]         grant_id_q;
    logic                  err_q;

    logic [REQ_NUM-1:0]    grant;
    logic [IW-1:0]         grant_idx;
    logic                  grant_any;
    logic                  can_grant;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    vc_rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr (
        .req       (req_valid_i),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready depends only on the registered count, never on this cycle's credit return.
    assign can_grant   = rst_n && (credit_q != '0);
    assign req_ready_o = can_grant ? grant : '0;
    assign accept      = can_grant && grant_any;

    always_comb begin
        sel_data = '0;
        for (int unsigned r = 0; r < REQ_NUM; r++) begin
            if (grant[r]) begin
                sel_data = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            credit_q   <= CW'(CREDIT_NUM);
            data_q     <= '0;
            valid_q    <= 1'b0;
            grant_id_q <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                data_q     <= sel_data;
                grant_id_q <= grant_idx;
                ptr_q      <= (grant_idx == IW'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;
            end

            // Accept with simultaneous credit return leaves the count unchanged.
            if (accept && !m_credit_i) begin
                credit_q <= credit_q - 1'b1;
            end else if (!accept && m_credit_i) begin
                if (credit_q == CW'(CREDIT_NUM)) begin
                    err_q <= 1'b1;
                end else begin
                    credit_q <= credit_q + 1'b1;
                end
            end
        end
    end

    assign m_data_o     = data_q;
    assign m_valid_o    = valid_q;
    assign m_grant_id_o = grant_id_q;
    assign credit_cnt_o = credit_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_vr_vc_arbiter.sv
// Directed self-checking bench for vr_vc_arbiter (DATA_WIDTH=8, CREDIT_NUM=2, REQ_NUM=4).
module tb_vr_vc_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_credit;
    logic [1:0]  m_grant_id;
    logic [1:0]  credit_cnt;
    logic        credit_err;

    int vectors;
    int miscompares;

    vr_vc_arbiter #(
        .DATA_WIDTH (8),
        .CREDIT_NUM (2),
        .REQ_NUM    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_credit_i   (m_credit),
        .m_grant_id_o (m_grant_id),
        .credit_cnt_o (credit_cnt),
        .credit_err_o (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_data    = '0;
        req_valid   = '0;
        m_credit    = 1'b0;

        // Reset held for two cycles; a valid request must not see ready.
        step();
        req_valid = 4'b0010;
        #1 chk("rst_ready_low", 32'(req_ready), 32'h0);
        step();
        chk("rst_cnt", 32'(credit_cnt), 32'd2);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'h0);
        chk("rst_id", 32'(m_grant_id), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        // Single beat from requester 1.
        req_data[15:8] = 8'hEE;
        req_valid      = 4'b0010;
        #1 chk("single_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'hEE);
        chk("single_id", 32'(m_grant_id), 32'd1);
        chk("single_cnt", 32'(credit_cnt), 32'd1);
        step();
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_data_hold", 32'(m_data), 32'hEE);
        chk("idle_id_hold", 32'(m_grant_id), 32'd1);
        m_credit = 1'b1;
        step();
        m_credit = 1'b0;
        chk("ret_cnt", 32'(credit_cnt), 32'd2);

        // Credit stall: three beats from requester 0, only two credits.
        req_data[7:0] = 8'h10;
        req_valid     = 4'b0001;
        #1 chk("stall_ready0", 32'(req_ready), 32'b0001);
        step();
        chk("stall_b0_data", 32'(m_data), 32'h10);
        chk("stall_b0_cnt", 32'(credit_cnt), 32'd1);
        req_data[7:0] = 8'h11;
        step();
        chk("stall_b1_valid", 32'(m_valid), 32'd1);
        chk("stall_b1_data", 32'(m_data), 32'h11);
        chk("stall_b1_cnt", 32'(credit_cnt), 32'd0);
        req_data[7:0] = 8'h12;
        #1 chk("stall_ready_zero", 32'(req_ready), 32'h0);
        step();
        chk("stall_wait_valid", 32'(m_valid), 32'd0);
        chk("stall_wait_data", 32'(m_data), 32'h11);
        chk("stall_wait_cnt", 32'(credit_cnt), 32'd0);
        m_credit = 1'b1;
        #1 chk("no_credit_bypass", 32'(req_ready), 32'h0);
        step();
        m_credit = 1'b0;
        chk("stall_cnt1", 32'(credit_cnt), 32'd1);
        chk("stall_cnt1_valid", 32'(m_valid), 32'd0);
        chk("stall_ready_again", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("stall_b2_valid", 32'(m_valid), 32'd1);
        chk("stall_b2_data", 32'(m_data), 32'h12);
        chk("stall_b2_cnt", 32'(credit_cnt), 32'd0);

        // Reset to start the round robin from pointer 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Round robin: all requesting, a credit returned every cycle.
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'b1111;
        m_credit  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_valid", 32'(m_valid), 32'd1);
            chk("rr_id", 32'(m_grant_id), 32'(k % 4));
            chk("rr_data", 32'(m_data), 32'hA0 + 32'(k % 4));
            chk("rr_cnt", 32'(credit_cnt), 32'd2);
        end
        req_valid = '0;
        m_credit  = 1'b0;
        step();
        chk("rr_end_valid", 32'(m_valid), 32'd0);
        chk("rr_end_err", 32'(credit_err), 32'd0);

        // Simultaneous accept and credit return at cnt=1.
        req_valid = 4'b0100;
        step();
        chk("sim_pre_cnt", 32'(credit_cnt), 32'd1);
        chk("sim_pre_id", 32'(m_grant_id), 32'd2);
        m_credit = 1'b1;
        step();
        req_valid = '0;
        m_credit  = 1'b0;
        chk("sim_cnt", 32'(credit_cnt), 32'd1);
        chk("sim_valid", 32'(m_valid), 32'd1);
        chk("sim_data", 32'(m_data), 32'hA2);

        // Overflow: credit returned while already full.
        m_credit = 1'b1;
        step();
        chk("ovf_fill_cnt", 32'(credit_cnt), 32'd2);
        chk("ovf_fill_err", 32'(credit_err), 32'd0);
        step();
        m_credit = 1'b0;
        chk("ovf_cnt", 32'(credit_cnt), 32'd2);
        chk("ovf_err", 32'(credit_err), 32'd1);
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        step();
        req_valid = '0;
        chk("ovf_sticky", 32'(credit_err), 32'd1);
        chk("ovf_beat_data", 32'(m_data), 32'h55);
        chk("ovf_beat_cnt", 32'(credit_cnt), 32'd1);

        // Reset mid-stream with cnt=0 and a beat in flight.
        req_valid = 4'b0001;
        step();
        chk("mid_cnt0", 32'(credit_cnt), 32'd0);
        chk("mid_inflight", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        chk("mid_rst_cnt", 32'(credit_cnt), 32'd2);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_err", 32'(credit_err), 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        #1 chk("mid_ptr_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("mid_ptr_id", 32'(m_grant_id), 32'd0);
        chk("mid_ptr_valid", 32'(m_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
